// File: rtl/booth_mult_32.sv
// Iterative radix-4 (modified Booth) signed multiplier.
// The product register {h, l} starts as {0, b, 0}. Each RUN cycle adds one Booth
// multiple of the multiplicand into h and then shifts the whole register right by
// two bits, keeping the sign. After WIDTH/2 steps the 64-bit product sits in
// {h[WIDTH-1:0], l[WIDTH:1]}. The low word and an overflow flag are registered
// from that value, and a one-cycle ready pulse goes out with them.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ctrl_mult
// RUN   | one Booth step per cycle; ctrl_mult here restarts with new operands
// DONE  | product complete; outputs load on this edge, ready pulses next cycle
module booth_mult_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int HW   = WIDTH + 2;          // accumulator; holds -2M for the most negative M
  localparam int LW   = WIDTH + 1;          // multiplier plus the implicit bit below its LSB
  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            load, step, finish;
  logic [CW-1:0]   count;
  logic [HW-1:0]   m, h, m2, addend, h_sum;
  logic [LW-1:0]   l;
  logic [2*WIDTH-1:0] product;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and datapath controls
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_mult) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (ctrl_mult) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          step = 1'b1;
          if (count == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        finish = 1'b1;
        if (ctrl_mult) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Booth recoding of the low triplet and the accumulator add
  always_comb begin
    m2 = m << 1;
    case (l[2:0])
      3'b001, 3'b010: addend = m;
      3'b011:         addend = m2;
      3'b100:         addend = -m2;
      3'b101, 3'b110: addend = -m;
      default:        addend = '0;
    endcase
    h_sum = h + addend;
  end

  // operand load and add-then-shift iteration
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m     <= '0;
      h     <= '0;
      l     <= '0;
      count <= '0;
    end else if (load) begin
      m     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
      h     <= '0;
      l     <= {data_operandB, 1'b0};
      count <= '0;
    end else if (step) begin
      h     <= {{2{h_sum[HW-1]}}, h_sum[HW-1:2]};
      l     <= {h_sum[1:0], l[LW-1:2]};
      count <= count + 1'b1;
    end
  end

  assign product = {h[WIDTH-1:0], l[LW-1:1]};

  // result registers, held until the next completed operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (finish) begin
        data_result    <= product[WIDTH-1:0];
        data_exception <= (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_32.sv
// Bench for booth_mult_32: directed corner cases, restart/reset/back-to-back flows,
// and a random signed sweep against a plain 64-bit multiply model.
module tb_booth_mult_32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int passes = 0;
  logic [31:0] last_lo = 32'h0;

  // 100 MHz clock
  always #5 clock = ~clock;

  booth_mult_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] lo, output logic e);
    longint p;
    p  = longint'($signed(x)) * longint'($signed(y));
    lo = p[31:0];
    e  = (longint'($signed(p[31:0])) != p);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // present operands with ctrl_mult for one edge, then scramble the inputs
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_mult     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // cycles after the start edge until ready is seen; -1 if it never comes
  task automatic wait_rdy(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_lo, input logic exp_e);
    int c;
    start_op(x, y);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " held"}, 64'(data_result), 64'(last_lo));
    wait_rdy(c);
    chk({tag, " latency"}, 64'(c), 64'd17);
    chk({tag, " result"}, 64'(data_result), 64'(exp_lo));
    chk({tag, " exc"}, 64'(data_exception), 64'(exp_e));
    last_lo = exp_lo;
    @(posedge clock);
    #1;
    chk({tag, " pulse"}, 64'(data_resultRDY), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] x, y, lo;
    logic        e;
    logic [31:0] corners [5];
    int          c;

    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    reset         = 1'b1;
    ctrl_mult     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset result", 64'(data_result), 64'd0);
    chk("reset exc", 64'(data_exception), 64'd0);
    chk("reset rdy", 64'(data_resultRDY), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // directed products
    run_check("7*-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_check("max*2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    run_check("2^16*2^16", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    run_check("min*-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_check("min*1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_check("min*min", 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);

    // restart mid-RUN: only the second operation reports
    start_op(32'd5, 32'd5);
    repeat (7) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_mult     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    wait_rdy(c);
    chk("restart latency", 64'(c), 64'd17);
    chk("restart result", 64'(data_result), 64'd12);
    chk("restart exc", 64'(data_exception), 64'd0);
    last_lo = 32'd12;

    // new start while in DONE: finished op still reports, new op runs
    start_op(32'd100, 32'hFFFF_FFF9);
    repeat (16) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd11;
    data_operandB = 32'd13;
    ctrl_mult     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    chk("done-load rdy", 64'(data_resultRDY), 64'd1);
    chk("done-load result", 64'(data_result), 64'hFFFF_FD44);
    chk("done-load busy", 64'(busy), 64'd1);
    wait_rdy(c);
    chk("done-load second latency", 64'(c), 64'd17);
    chk("done-load second result", 64'(data_result), 64'd143);
    last_lo = 32'd143;

    // asynchronous reset in the middle of RUN
    start_op(32'd9, 32'd9);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset result", 64'(data_result), 64'd0);
    chk("async reset exc", 64'(data_exception), 64'd0);
    chk("async reset rdy", 64'(data_resultRDY), 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset   = 1'b0;
    last_lo = 32'h0;
    wait_rdy(c);
    chk("no rdy after reset", 64'(c), 64'hFFFF_FFFF_FFFF_FFFF);
    run_check("6*7", 32'd6, 32'd7, 32'd42, 1'b0);

    // every pairing of the corner operands
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        model(corners[i], corners[j], lo, e);
        run_check($sformatf("corner %0d*%0d", i, j), corners[i], corners[j], lo, e);
      end
    end

    // random signed sweep with corners mixed in
    for (int k = 0; k < 1000; k++) begin
      x = pick();
      y = pick();
      model(x, y, lo, e);
      run_check($sformatf("rand %0d %h*%h", k, x, y), x, y, lo, e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
